lpif_ustrm_credit_arb: RTL and testbench

//  Shares the single upstream logic-link word (273b: bit 272 = valid, [271:0] = LPIF payload) between two requesters.
//  Two-way round-robin arbiter gated by a transmit credit counter that tracks free entries in the far-end RX FIFO.

---
 rtl/lpif_ustrm_credit_arb_if.sv | 27 ++
 rtl/lpif_ustrm_credit_arb.sv | 118 +++++++++++
 tb/tb_lpif_ustrm_credit_arb.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/lpif_ustrm_credit_arb_if.sv
// Upstream LPIF source bundle: two requesters, credit return and TX FIFO push side.
// slave = arbiter side, master = sources / TX FIFO / link side.
interface lpif_ustrm_credit_arb_if #(
  parameter int unsigned PAYLOAD_W = 272,
  parameter int unsigned CREDIT_W  = 4
);
  logic                   rx_online;
  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [PAYLOAD_W-1:0]   req0_payload;
  logic [PAYLOAD_W-1:0]   req1_payload;
  logic                   credit_return;
  logic [PAYLOAD_W:0]     txfifo_upstream_data;
  logic                   txfifo_upstream_push;
  logic [CREDIT_W-1:0]    credit_cnt;
  logic                   credit_err;

  modport slave (
    input  rx_online, req_valid, req0_payload, req1_payload, credit_return,
    output req_ready, txfifo_upstream_data, txfifo_upstream_push, credit_cnt, credit_err
  );

  modport master (
    output rx_online, req_valid, req0_payload, req1_payload, credit_return,
    input  req_ready, txfifo_upstream_data, txfifo_upstream_push, credit_cnt, credit_err
  );
endinterface

// File: rtl/lpif_ustrm_credit_arb.sv
// Two-way round-robin arbiter for the upstream logic-link word, gated by far-end RX FIFO
// credits; owns the credit init/clear sequence across link up/down.
module lpif_ustrm_credit_arb #(
  parameter int unsigned PAYLOAD_W  = 272,
  parameter int unsigned CREDIT_MAX = 8,
  parameter int unsigned CREDIT_W   = 4
) (
  input  logic                  clk_wr,
  input  logic                  rst_wr_n,
  lpif_ustrm_credit_arb_if.slave lpif_io
);

  localparam logic [CREDIT_W-1:0] CreditMax = CREDIT_W'(CREDIT_MAX);

  typedef enum logic [1:0] {StOffline, StInit, StActive} state_e;

  state_e                state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic                  err_q, err_d;
  logic                  rr_q, rr_d;
  logic                  push_q, push_d;
  logic [PAYLOAD_W-1:0]  payload_q, payload_d;

  logic                  can_grant, load_max, clear_cnt;
  logic [1:0]            grant;
  logic                  hs;

  // State register
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) state_q <= StOffline;
    else           state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StOffline: if (lpif_io.rx_online) state_d = StInit;
      StInit:    state_d = lpif_io.rx_online ? StActive : StOffline;
      StActive:  if (!lpif_io.rx_online) state_d = StOffline;
      default:   state_d = StOffline;
    endcase
  end

  // FSM outputs
  always_comb begin
    can_grant = 1'b0;
    load_max  = 1'b0;
    clear_cnt = 1'b0;
    unique case (state_q)
      StOffline: clear_cnt = 1'b1;
      StInit:    begin
        load_max  = lpif_io.rx_online;
        clear_cnt = !lpif_io.rx_online;
      end
      StActive:  begin
        can_grant = lpif_io.rx_online && (credit_q != '0);
        clear_cnt = !lpif_io.rx_online;
      end
      default:   clear_cnt = 1'b1;
    endcase
  end

  // Grant is driven by the registered count only, so a same-cycle return cannot enable it
  always_comb begin
    grant[0] = can_grant && lpif_io.req_valid[0] && (!lpif_io.req_valid[1] || !rr_q);
    grant[1] = can_grant && lpif_io.req_valid[1] && (!lpif_io.req_valid[0] ||  rr_q);
    hs       = |(grant & lpif_io.req_valid);
  end

  always_comb begin
    rr_d      = rr_q;
    push_d    = hs;
    payload_d = payload_q;
    credit_d  = credit_q;
    err_d     = err_q;
    if (grant[0]) begin
      rr_d      = 1'b1;
      payload_d = lpif_io.req0_payload;
    end else if (grant[1]) begin
      rr_d      = 1'b0;
      payload_d = lpif_io.req1_payload;
    end
    if (clear_cnt) begin
      credit_d = '0;
    end else if (load_max) begin
      credit_d = CreditMax;
    end else if (hs && !lpif_io.credit_return) begin
      credit_d = credit_q - 1'b1;
    end else if (!hs && lpif_io.credit_return) begin
      if (credit_q == CreditMax) err_d    = 1'b1;
      else                       credit_d = credit_q + 1'b1;
    end
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      credit_q  <= '0;
      err_q     <= 1'b0;
      rr_q      <= 1'b0;
      push_q    <= 1'b0;
      payload_q <= '0;
    end else begin
      credit_q  <= credit_d;
      err_q     <= err_d;
      rr_q      <= rr_d;
      push_q    <= push_d;
      payload_q <= payload_d;
    end
  end

  assign lpif_io.req_ready            = grant;
  assign lpif_io.txfifo_upstream_data = {push_q, payload_q};
  assign lpif_io.txfifo_upstream_push = push_q;
  assign lpif_io.credit_cnt           = credit_q;
  assign lpif_io.credit_err           = err_q;

endmodule

// File: tb/tb_lpif_ustrm_credit_arb.sv
// Directed bench for lpif_ustrm_credit_arb: credit init, round-robin, credit edge cases,
// overflow flag and link drop/re-raise.
module tb_lpif_ustrm_credit_arb;

  localparam int unsigned PW = 272;

  logic clk_wr;
  logic rst_wr_n;
  int   n_checks;
  int   n_pass;

  lpif_ustrm_credit_arb_if #(.PAYLOAD_W(PW), .CREDIT_W(4)) lpif_if ();

  lpif_ustrm_credit_arb #(
    .PAYLOAD_W (PW),
    .CREDIT_MAX(8),
    .CREDIT_W  (4)
  ) dut (
    .clk_wr  (clk_wr),
    .rst_wr_n(rst_wr_n),
    .lpif_io (lpif_if.slave)
  );

  initial clk_wr = 1'b0;
  always #5 clk_wr = ~clk_wr;

  task automatic check(input string tag, input logic [PW:0] got, input logic [PW:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [PW-1:0] mk(input logic [15:0] s);
    return {17{s}};
  endfunction

  task automatic step();
    @(posedge clk_wr);
    #1;
  endtask

  task automatic ret_credits(input int n);
    for (int k = 0; k < n; k++) begin
      lpif_if.credit_return = 1'b1;
      step();
      lpif_if.credit_return = 1'b0;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_wr_n = 1'b0;
    lpif_if.rx_online     = 1'b0;
    lpif_if.req_valid     = 2'b00;
    lpif_if.req0_payload  = '0;
    lpif_if.req1_payload  = '0;
    lpif_if.credit_return = 1'b0;
    step();
    step();
    check("rst_cnt",   lpif_if.credit_cnt, 0);
    check("rst_push",  lpif_if.txfifo_upstream_push, 0);
    check("rst_data",  lpif_if.txfifo_upstream_data, 0);
    check("rst_ready", lpif_if.req_ready, 0);
    check("rst_err",   lpif_if.credit_err, 0);
    rst_wr_n = 1'b1;
    step();

    // 1: link up, INIT, then three req0 words
    lpif_if.rx_online = 1'b1;
    step();
    check("init_cnt0", lpif_if.credit_cnt, 0);
    lpif_if.req_valid = 2'b01;
    #1 check("init_noready", lpif_if.req_ready, 0);
    lpif_if.req_valid = 2'b00;
    step();
    check("init_cnt8", lpif_if.credit_cnt, 8);
    for (int i = 0; i < 3; i++) begin
      lpif_if.req0_payload = mk(16'hA000 + 16'(i));
      lpif_if.req_valid    = 2'b01;
      #1 check("t1_ready", lpif_if.req_ready, 2'b01);
      step();
      check("t1_push", lpif_if.txfifo_upstream_push, 1);
      check("t1_data", lpif_if.txfifo_upstream_data, {1'b1, mk(16'hA000 + 16'(i))});
      check("t1_cnt",  lpif_if.credit_cnt, 4'(7 - i));
    end
    lpif_if.req_valid = 2'b00;
    step();
    check("t1_idle_push", lpif_if.txfifo_upstream_push, 0);
    check("t1_idle_data", lpif_if.txfifo_upstream_data, {1'b0, mk(16'hA002)});

    // single req1 word so the pointer favours req0 next, then refill to 8
    lpif_if.req1_payload = mk(16'hB000);
    lpif_if.req_valid    = 2'b10;
    #1 check("r1_ready", lpif_if.req_ready, 2'b10);
    step();
    lpif_if.req_valid = 2'b00;
    check("r1_data", lpif_if.txfifo_upstream_data, {1'b1, mk(16'hB000)});
    check("r1_cnt",  lpif_if.credit_cnt, 4);
    ret_credits(4);
    check("refill_cnt", lpif_if.credit_cnt, 8);

    // 2: both valid, alternating grants until credits run out
    for (int i = 0; i < 8; i++) begin
      lpif_if.req0_payload = mk(16'hC000 + 16'(i));
      lpif_if.req1_payload = mk(16'hD000 + 16'(i));
      lpif_if.req_valid    = 2'b11;
      #1 check("t2_ready", lpif_if.req_ready, (i % 2 == 1) ? 2'b10 : 2'b01);
      step();
      check("t2_data", lpif_if.txfifo_upstream_data,
            {1'b1, (i % 2 == 1) ? mk(16'hD000 + 16'(i)) : mk(16'hC000 + 16'(i))});
      check("t2_cnt", lpif_if.credit_cnt, 4'(7 - i));
    end
    #1 check("t2_stall_ready", lpif_if.req_ready, 0);
    check("t2_stall_cnt", lpif_if.credit_cnt, 0);
    lpif_if.req_valid = 2'b00;

    // 3: return at zero credits does not grant in the same cycle
    lpif_if.req0_payload  = mk(16'hE000);
    lpif_if.req_valid     = 2'b01;
    lpif_if.credit_return = 1'b1;
    #1 check("t3_noready", lpif_if.req_ready, 0);
    step();
    lpif_if.credit_return = 1'b0;
    check("t3_cnt1", lpif_if.credit_cnt, 1);
    check("t3_nopush", lpif_if.txfifo_upstream_push, 0);
    #1 check("t3_ready", lpif_if.req_ready, 2'b01);
    step();
    lpif_if.req_valid = 2'b00;
    check("t3_data", lpif_if.txfifo_upstream_data, {1'b1, mk(16'hE000)});
    check("t3_cnt0", lpif_if.credit_cnt, 0);

    // 4: handshake and return together at 3 credits
    ret_credits(3);
    check("t4_pre", lpif_if.credit_cnt, 3);
    lpif_if.req0_payload  = mk(16'hF000);
    lpif_if.req_valid     = 2'b01;
    lpif_if.credit_return = 1'b1;
    #1 check("t4_ready", lpif_if.req_ready, 2'b01);
    step();
    lpif_if.req_valid     = 2'b00;
    lpif_if.credit_return = 1'b0;
    check("t4_cnt", lpif_if.credit_cnt, 3);
    check("t4_push", lpif_if.txfifo_upstream_push, 1);

    // 5: overflow return sets the sticky error
    ret_credits(5);
    check("t5_full", lpif_if.credit_cnt, 8);
    check("t5_noerr", lpif_if.credit_err, 0);
    ret_credits(1);
    check("t5_cnt", lpif_if.credit_cnt, 8);
    check("t5_err", lpif_if.credit_err, 1);
    step();
    step();
    check("t5_sticky", lpif_if.credit_err, 1);

    // 6: link drop while streaming, then re-raise
    lpif_if.req1_payload = mk(16'h1100);
    lpif_if.req_valid    = 2'b10;
    #1 check("t6_ready", lpif_if.req_ready, 2'b10);
    step();
    check("t6_cnt7", lpif_if.credit_cnt, 7);
    lpif_if.req1_payload = mk(16'h1101);
    step();
    check("t6_cnt6", lpif_if.credit_cnt, 6);
    lpif_if.rx_online = 1'b0;
    #1 check("t6_drop_ready", lpif_if.req_ready, 0);
    check("t6_last_push", lpif_if.txfifo_upstream_push, 1);
    check("t6_last_data", lpif_if.txfifo_upstream_data, {1'b1, mk(16'h1101)});
    step();
    check("t6_cnt0", lpif_if.credit_cnt, 0);
    check("t6_nopush", lpif_if.txfifo_upstream_push, 0);
    check("t6_off_ready", lpif_if.req_ready, 0);
    lpif_if.req_valid = 2'b00;
    lpif_if.rx_online = 1'b1;
    step();
    check("t6_init_cnt", lpif_if.credit_cnt, 0);
    step();
    check("t6_up_cnt", lpif_if.credit_cnt, 8);
    check("t6_err_kept", lpif_if.credit_err, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
